// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter. The frame format is
// configurable (5-8 data bits, none/even/odd parity, 1 or 2 stop bits) and
// the bit period is baud_div+1 clocks. All frame settings are captured when a
// byte is popped, so they cannot change in the middle of a frame.
module uart_tx_param #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    data_bits,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop_bits,
  output logic                          uart_tx,
  output logic                          tx_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // FIFO storage; pointers carry one extra wrap bit so full and empty differ
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  head;
  logic        push;
  logic        pop;

  // Frame state, all latched at pop time
  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_l;
  logic [2:0]       bit_idx;
  logic [2:0]       last_bit;
  logic [7:0]       shreg;
  logic             par_en;
  logic             par_bit;
  logic             stop_l;
  logic             stop_idx;
  logic [7:0]       mask;
  logic             bit_end;
  logic             frame_end;

  assign fifo_level = wr_ptr - rd_ptr;
  assign tx_ready   = (fifo_level < FULL_LVL);
  assign push       = tx_valid && tx_ready;
  assign head       = mem[rd_ptr[AW-1:0]];

  assign bit_end    = (cnt == div_l);
  assign frame_end  = (state == STOP) && bit_end && (stop_idx == stop_l);
  // A byte leaves the FIFO either from IDLE or exactly at the end of the
  // previous frame, which gives back-to-back frames with no idle gap.
  assign pop        = (fifo_level != '0) && ((state == IDLE) || frame_end);

  // Data-length mask so bits above the configured length never reach parity
  always_comb begin
    mask = 8'hFF;
    case (data_bits)
      2'b00:   mask = 8'h1F;
      2'b01:   mask = 8'h3F;
      2'b10:   mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
  end

  // FIFO write port (no reset needed on the storage itself)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
  end

  // FIFO pointer update; reset empties the FIFO and blocks any push
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Transmit FSM with registered line, done pulse and busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      uart_tx  <= 1'b1;
      tx_done  <= 1'b0;
      busy     <= 1'b0;
      cnt      <= '0;
      div_l    <= '0;
      bit_idx  <= '0;
      last_bit <= '0;
      shreg    <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      stop_l   <= 1'b0;
      stop_idx <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (pop) begin
        state    <= START;
        uart_tx  <= 1'b0;
        busy     <= 1'b1;
        cnt      <= '0;
        div_l    <= (baud_div == '0) ? DIV_W'(1) : baud_div;
        last_bit <= 3'(3'd4 + {1'b0, data_bits});
        shreg    <= head;
        par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        par_bit  <= (^(head & mask)) ^ (parity_mode == 2'b10);
        stop_l   <= stop_bits;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            uart_tx <= 1'b1;
          end
          START: begin
            if (bit_end) begin
              state   <= DATA;
              cnt     <= '0;
              uart_tx <= shreg[0];
            end else begin
              cnt <= cnt + DIV_W'(1);
            end
          end
          DATA: begin
            if (bit_end) begin
              cnt <= '0;
              if (bit_idx == last_bit) begin
                if (par_en) begin
                  state   <= PARITY;
                  uart_tx <= par_bit;
                end else begin
                  state   <= STOP;
                  uart_tx <= 1'b1;
                end
              end else begin
                bit_idx <= bit_idx + 3'd1;
                uart_tx <= shreg[1];
                shreg   <= shreg >> 1;
              end
            end else begin
              cnt <= cnt + DIV_W'(1);
            end
          end
          PARITY: begin
            if (bit_end) begin
              state   <= STOP;
              cnt     <= '0;
              uart_tx <= 1'b1;
            end else begin
              cnt <= cnt + DIV_W'(1);
            end
          end
          STOP: begin
            uart_tx <= 1'b1;
            if (bit_end) begin
              cnt <= '0;
              if (stop_idx == stop_l) begin
                // FIFO is empty here, otherwise pop would have fired
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                stop_idx <= 1'b1;
              end
            end else begin
              cnt <= cnt + DIV_W'(1);
              // done is visible during the very last clock of the last stop bit
              if ((stop_idx == stop_l) && (cnt == div_l - DIV_W'(1)))
                tx_done <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            uart_tx <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed bench for uart_tx_param. Each task drives one
// scenario and compares the observed line/flags with hand-derived values.
module tb_uart_tx_param;

  logic        clk;
  logic        reset;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic [1:0]  parity_mode;
  logic        stop_bits;
  logic        uart_tx;
  logic        tx_done;
  logic        busy;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;

  uart_tx_param #(.DIV_W(16), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .baud_div   (baud_div),
    .data_bits  (data_bits),
    .parity_mode(parity_mode),
    .stop_bits  (stop_bits),
    .uart_tx    (uart_tx),
    .tx_done    (tx_done),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the line drops; returns positioned on start clock 0
  task automatic wait_start(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      tick();
      if (uart_tx === 1'b0) ok = 1'b1;
    end
  endtask

  // Record nbits bit periods of p clocks each, starting on the current clock.
  // A bit that is not stable for all p clocks is reported as 'x'.
  task automatic measure(input int nbits, input int p, output string obs,
                         output int done_at, output int done_cnt);
    logic v;
    bit   stable;
    obs      = "";
    done_at  = -1;
    done_cnt = 0;
    for (int b = 0; b < nbits; b++) begin
      v      = uart_tx;
      stable = 1'b1;
      for (int c = 0; c < p; c++) begin
        if (uart_tx !== v) stable = 1'b0;
        if (tx_done === 1'b1) begin
          if (done_at < 0) done_at = b * p + c;
          done_cnt++;
        end
        tick();
      end
      if (!stable || v === 1'bx || v === 1'bz) obs = {obs, "x"};
      else if (v) obs = {obs, "1"};
      else obs = {obs, "0"};
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hAA;
    repeat (3) tick();
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_uart_tx got=%b want=1", uart_tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_tx_done got=%b want=0", tx_done); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", tx_ready); end
    tx_valid = 1'b0;
    reset    = 1'b0;
    tick();
    total++; if (uart_tx !== 1'b1 || fifo_level !== 3'd0) begin
      bad++; $display("FAIL reset_release line=%b level=%0d want line=1 level=0", uart_tx, fifo_level);
    end
  endtask

  task automatic test_8n1();
    string obs;
    int    d_at, d_cnt;
    baud_div = 16'd3; data_bits = 2'b11; parity_mode = 2'b00; stop_bits = 1'b0;
    tx_data = 8'h55; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    total++; if (fifo_level !== 3'd1 || uart_tx !== 1'b1) begin
      bad++; $display("FAIL 8n1_after_push level=%0d line=%b want level=1 line=1", fifo_level, uart_tx);
    end
    tick();
    total++; if (uart_tx !== 1'b0 || busy !== 1'b1 || fifo_level !== 3'd0) begin
      bad++; $display("FAIL 8n1_start_latency line=%b busy=%b level=%0d want 0 1 0", uart_tx, busy, fifo_level);
    end
    measure(11, 4, obs, d_at, d_cnt);
    total++; if (obs != "01010101011") begin bad++; $display("FAIL 8n1_bits got=%s want=01010101011", obs); end
    total++; if (d_at !== 39 || d_cnt !== 1) begin
      bad++; $display("FAIL 8n1_done at=%0d cnt=%0d want at=39 cnt=1", d_at, d_cnt);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL 8n1_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_7e2();
    string obs;
    int    d_at, d_cnt;
    bit    ok;
    baud_div = 16'd9; data_bits = 2'b10; parity_mode = 2'b01; stop_bits = 1'b1;
    tx_data = 8'h41; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    wait_start(10, ok);
    total++; if (!ok) begin bad++; $display("FAIL 7e2_start got=no_start want=start"); end
    // start, data 1000001, even parity 0, two stops
    measure(11, 10, obs, d_at, d_cnt);
    total++; if (obs != "01000001011") begin bad++; $display("FAIL 7e2_bits got=%s want=01000001011", obs); end
    total++; if (d_at !== 109 || d_cnt !== 1) begin
      bad++; $display("FAIL 7e2_done at=%0d cnt=%0d want at=109 cnt=1", d_at, d_cnt);
    end
    total++; if (busy !== 1'b0 || uart_tx !== 1'b1) begin
      bad++; $display("FAIL 7e2_idle busy=%b line=%b want 0 1", busy, uart_tx);
    end
  endtask

  task automatic test_5o1();
    string obs;
    int    d_at, d_cnt;
    // baud_div 0 behaves as 1: two clocks per bit
    baud_div = 16'd0; data_bits = 2'b00; parity_mode = 2'b10; stop_bits = 1'b0;
    tx_data = 8'h1F; tx_valid = 1'b1;
    tick();
    tx_data = 8'hE3;
    tick();
    tx_valid = 1'b0;
    total++; if (uart_tx !== 1'b0 || fifo_level !== 3'd1) begin
      bad++; $display("FAIL 5o1_push_pop line=%b level=%0d want line=0 level=1", uart_tx, fifo_level);
    end
    // 0x1F: data 11111, odd parity 0
    measure(8, 2, obs, d_at, d_cnt);
    total++; if (obs != "01111101") begin bad++; $display("FAIL 5o1_1f got=%s want=01111101", obs); end
    total++; if (d_at !== 15 || d_cnt !== 1) begin
      bad++; $display("FAIL 5o1_1f_done at=%0d cnt=%0d want at=15 cnt=1", d_at, d_cnt);
    end
    // 0xE3 low five bits: data 11000, odd parity over those bits is 1
    measure(8, 2, obs, d_at, d_cnt);
    total++; if (obs != "01100011") begin bad++; $display("FAIL 5o1_e3 got=%s want=01100011", obs); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL 5o1_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6];
    string      exp [6];
    string      obs;
    int         d_at, d_cnt;
    int         k;
    bit         ok;
    bytes[0] = 8'h01; exp[0] = "0100000001";
    bytes[1] = 8'h02; exp[1] = "0010000001";
    bytes[2] = 8'h80; exp[2] = "0000000011";
    bytes[3] = 8'hFF; exp[3] = "0111111111";
    bytes[4] = 8'h00; exp[4] = "0000000001";
    bytes[5] = 8'hA5; exp[5] = "0101001011";
    baud_div = 16'd1; data_bits = 2'b11; parity_mode = 2'b00; stop_bits = 1'b0;
    k = 0;
    fork
      begin
        bit acc;
        tx_valid = 1'b1;
        for (int i = 0; i < 400 && k < 6; i++) begin
          tx_data = bytes[k];
          acc = tx_ready;
          if (i == 5) begin
            total++; if (tx_ready !== 1'b0 || fifo_level !== 3'd4 || k !== 5) begin
              bad++; $display("FAIL b2b_full ready=%b level=%0d pushed=%0d want 0 4 5", tx_ready, fifo_level, k);
            end
          end
          tick();
          if (acc) k++;
        end
        tx_valid = 1'b0;
      end
      begin
        wait_start(10, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_start got=no_start want=start"); end
        for (int f = 0; f < 6; f++) begin
          measure(10, 2, obs, d_at, d_cnt);
          total++; if (obs != exp[f] || d_at !== 19 || d_cnt !== 1) begin
            bad++; $display("FAIL b2b_frame%0d got=%s done_at=%0d cnt=%0d want=%s done_at=19 cnt=1",
                            f, obs, d_at, d_cnt, exp[f]);
          end
        end
      end
    join
    total++; if (k !== 6) begin bad++; $display("FAIL b2b_pushed got=%0d want=6", k); end
    total++; if (busy !== 1'b0 || uart_tx !== 1'b1 || fifo_level !== 3'd0) begin
      bad++; $display("FAIL b2b_idle busy=%b line=%b level=%0d want 0 1 0", busy, uart_tx, fifo_level);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int dones;
    int highs;
    baud_div = 16'd3; data_bits = 2'b11; parity_mode = 2'b00; stop_bits = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'h00; tick();
    tx_data = 8'h11; tick();
    tx_data = 8'h22; tick();
    tx_valid = 1'b0;
    total++; if (fifo_level !== 3'd2) begin bad++; $display("FAIL rst_mid_queued got=%0d want=2", fifo_level); end
    // We are 2 clocks into the start bit; move to the middle of data bit 4
    repeat (16) tick();
    total++; if (uart_tx !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL rst_mid_before line=%b busy=%b want 0 1", uart_tx, busy);
    end
    reset = 1'b1; tx_valid = 1'b1; tx_data = 8'h33;
    tick();
    reset = 1'b0; tx_valid = 1'b0;
    total++; if (uart_tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0 || tx_done !== 1'b0) begin
      bad++; $display("FAIL rst_mid_after line=%b busy=%b level=%0d done=%b want 1 0 0 0",
                      uart_tx, busy, fifo_level, tx_done);
    end
    dones = 0; highs = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx_done === 1'b1) dones++;
      if (uart_tx === 1'b1) highs++;
    end
    total++; if (dones !== 0 || highs !== 60) begin
      bad++; $display("FAIL rst_mid_quiet dones=%0d high_clocks=%0d want 0 60", dones, highs);
    end
    ok = 1'b1;
  endtask

  task automatic test_baud_change();
    string obs;
    int    d_at, d_cnt;
    baud_div = 16'd3; data_bits = 2'b11; parity_mode = 2'b00; stop_bits = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'h55; tick();
    tx_data = 8'h0F; tick();
    tx_valid = 1'b0;
    baud_div = 16'd7;
    measure(10, 4, obs, d_at, d_cnt);
    total++; if (obs != "0101010101" || d_at !== 39) begin
      bad++; $display("FAIL baud_first got=%s done_at=%0d want=0101010101 done_at=39", obs, d_at);
    end
    measure(10, 8, obs, d_at, d_cnt);
    total++; if (obs != "0111100001" || d_at !== 79 || d_cnt !== 1) begin
      bad++; $display("FAIL baud_second got=%s done_at=%0d cnt=%0d want=0111100001 done_at=79 cnt=1",
                      obs, d_at, d_cnt);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL baud_busy_end got=%b want=0", busy); end
  endtask

  initial begin
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    baud_div = 16'd3; data_bits = 2'b11; parity_mode = 2'b00; stop_bits = 1'b0;
    test_reset();
    test_8n1();
    test_7e2();
    test_5o1();
    test_back_to_back();
    test_reset_mid_frame();
    test_baud_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
